// File: rtl/play_timer_pkg.sv
// Shared types and constants for the MM:SS play timer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package play_timer_pkg;

    typedef enum logic [1:0] {
        ST_PAUSE = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Largest value each BCD digit may hold before it rolls over
    localparam logic [3:0] BCD_MAX_SEC_L = 4'd9;
    localparam logic [3:0] BCD_MAX_SEC_H = 4'd5;
    localparam logic [3:0] BCD_MAX_MIN   = 4'd9;

    localparam int unsigned ELAPSED_W = 12;

    // True when the whole display reads 99:59 and must stop advancing
    function automatic logic at_display_max(input logic [3:0] min_h,
                                            input logic [3:0] min_l,
                                            input logic [3:0] sec_h,
                                            input logic [3:0] sec_l);
        return (min_h == BCD_MAX_MIN) && (min_l == BCD_MAX_MIN) &&
               (sec_h == BCD_MAX_SEC_H) && (sec_l == BCD_MAX_SEC_L);
    endfunction

endpackage

// File: rtl/play_timer_if.sv
// Control inputs and MM:SS display outputs of the play timer.
// Latency: n/a (signal bundle only).
// Backpressure: none; all signals are levels or single-cycle pulses.
// master: drives music_select/play/song_len, receives digits and pulses.
// slave : the timer itself.
interface play_timer_if;
    logic [4:0]  music_select;
    logic        play;
    logic [11:0] song_len;
    logic [3:0]  sec_l;
    logic [3:0]  sec_h;
    logic [3:0]  min_l;
    logic [3:0]  min_h;
    logic        sec_tick;
    logic        song_end;

    modport master (
        output music_select, play, song_len,
        input  sec_l, sec_h, min_l, min_h, sec_tick, song_end
    );

    modport slave (
        input  music_select, play, song_len,
        output sec_l, sec_h, min_l, min_h, sec_tick, song_end
    );
endinterface

// File: rtl/play_timer_bcd_digit.sv
// One BCD display digit that counts 0..MAX and carries out when it wraps.
// Latency: digit updates on the clock edge after inc_i/clr_i; carry_o is combinational.
// Backpressure: none; clr_i has priority over inc_i.
// Ports: clk_vga, rst_n, clr_i, inc_i -> digit_o (registered), carry_o.
module bcd_digit
    import play_timer_pkg::*;
#(
    parameter logic [3:0] MAX = BCD_MAX_SEC_L
)
(
    input  logic       clk_vga,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [3:0] digit_o,
    output logic       carry_o
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr_i) begin
            digit_d = 4'd0;
        end else if (inc_i) begin
            digit_d = (digit_q == MAX) ? 4'd0 : digit_q + 4'd1;
        end
    end

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    // Carry is suppressed by clear so a restart never ripples into the next digit
    assign carry_o = inc_i && !clr_i && (digit_q == MAX);
    assign digit_o = digit_q;

endmodule

// File: rtl/play_timer.sv
// Elapsed play time as registered BCD MM:SS with second tick and optional end-of-song pulse.
// Latency: sec_tick and digits update together on the edge the prescaler wraps; song_end one cycle after that tick.
// Backpressure: none; play is a level, a music_select change restarts timing immediately.
// Ports: clk_vga, rst_n (async, active low); bus (slave): music_select, play, song_len in;
//        sec_l/sec_h/min_l/min_h, sec_tick, song_end out.
// Build option: define PLAY_TIMER_END_DET_EN to add song_end detection and the DONE state;
// otherwise song_end is tied low and song_len is ignored.
module play_timer
    import play_timer_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 65000000
)
(
    input  logic          clk_vga,
    input  logic          rst_n,
    play_timer_if.slave   bus
);

    localparam int unsigned PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ - 1);

    state_e         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [4:0]     sel_q;
    logic           tick_q;

    logic           restart;
    logic           run_en;
    logic           wrap;
    logic           sat;
    logic           inc;
    logic           end_hit;

    logic [3:0]     sec_l, sec_h, min_l, min_h;
    logic           c_sec_l, c_sec_h, c_min_l;
    logic           carry_unused;

    // Any change of track, including one coinciding with a wrap or song end, wins
    assign restart = (bus.music_select != sel_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_PAUSE: if (bus.play) state_d = ST_RUN;
            ST_RUN: begin
                if (end_hit) begin
                    state_d = ST_DONE;
                end else if (!bus.play) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_PAUSE;
        endcase
        if (restart) begin
            state_d = bus.play ? ST_RUN : ST_PAUSE;
        end
    end

    // The prescaler counts every cycle whose next state is RUN, so the first
    // cycle play is seen already counts and a second is exactly CLK_FREQ
    // playing cycles. Paused/done cycles hold the fraction.
    assign run_en = (state_d == ST_RUN) && !restart;
    assign wrap   = run_en && (presc_q == PRESC_LAST);
    assign sat    = at_display_max(min_h, min_l, sec_h, sec_l);
    assign inc    = wrap && !sat;

    always_comb begin
        presc_d = presc_q;
        if (restart) begin
            presc_d = '0;
        end else if (run_en) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_PAUSE;
            presc_q <= '0;
            sel_q   <= 5'd0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            sel_q   <= bus.music_select;
            tick_q  <= inc;
        end
    end

    bcd_digit #(.MAX(BCD_MAX_SEC_L)) u_sec_l (
        .clk_vga (clk_vga), .rst_n (rst_n), .clr_i (restart),
        .inc_i   (inc),     .digit_o (sec_l), .carry_o (c_sec_l)
    );

    bcd_digit #(.MAX(BCD_MAX_SEC_H)) u_sec_h (
        .clk_vga (clk_vga), .rst_n (rst_n), .clr_i (restart),
        .inc_i   (c_sec_l), .digit_o (sec_h), .carry_o (c_sec_h)
    );

    bcd_digit #(.MAX(BCD_MAX_MIN)) u_min_l (
        .clk_vga (clk_vga), .rst_n (rst_n), .clr_i (restart),
        .inc_i   (c_sec_h), .digit_o (min_l), .carry_o (c_min_l)
    );

    // min_h never reaches its carry: increments stop at 99:59
    bcd_digit #(.MAX(BCD_MAX_MIN)) u_min_h (
        .clk_vga (clk_vga), .rst_n (rst_n), .clr_i (restart),
        .inc_i   (c_min_l), .digit_o (min_h), .carry_o (carry_unused)
    );

    assign bus.sec_l    = sec_l;
    assign bus.sec_h    = sec_h;
    assign bus.min_l    = min_l;
    assign bus.min_h    = min_h;
    assign bus.sec_tick = tick_q;

`ifdef PLAY_TIMER_END_DET_EN
    logic [ELAPSED_W-1:0] elapsed_q;
    logic                 end_q;

    // Equality is only tested on the cycle right after a tick, so lowering
    // song_len below the elapsed time can never trigger a late end pulse.
    assign end_hit = tick_q && (bus.song_len != '0) && (elapsed_q == bus.song_len);

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            elapsed_q <= '0;
            end_q     <= 1'b0;
        end else begin
            if (restart) begin
                elapsed_q <= '0;
            end else if (inc && !(&elapsed_q)) begin
                elapsed_q <= elapsed_q + ELAPSED_W'(1);
            end
            end_q <= end_hit && !restart;
        end
    end

    assign bus.song_end = end_q;
`else
    logic unused_song_len;

    assign end_hit         = 1'b0;
    assign unused_song_len = ^bus.song_len;
    assign bus.song_end    = 1'b0;
`endif

endmodule
